// File: rtl/mem_arbiter.sv
// Two-port arbiter for a single-port synchronous-read data memory, with short locked sequences.
// Define MEM_ARBITER_ROUND_ROBIN_EN to alternate grants under contention instead of favouring port 0.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int LOCK_MAX   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_in
);
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_P0 = 2'd1, OWN_P1 = 2'd2} owner_t;

    localparam logic [3:0] LOCK_LIM = 4'(LOCK_MAX);

    logic       last_gnt;
    owner_t     lock_owner;
    logic [3:0] lock_cnt;
    logic       rd_pend;
    logic       rd_port;
    logic       expired;
    owner_t     gnt_owner;

    // Lock budget used up: the held lock is ignored for this arbitration.
    assign expired = (lock_owner != OWN_NONE) && (lock_cnt >= LOCK_LIM);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst_n) begin
            gnt0 = 1'b0;
        end else if (lock_owner == OWN_P0 && req0 && !expired) begin
            gnt0 = 1'b1;
        end else if (lock_owner == OWN_P1 && req1 && !expired) begin
            gnt1 = 1'b1;
        end else if (req0 && !req1) begin
            gnt0 = 1'b1;
        end else if (req1 && !req0) begin
            gnt1 = 1'b1;
        end else if (req0 && req1) begin
            if (expired) begin
                gnt0 = (lock_owner == OWN_P1);
                gnt1 = (lock_owner == OWN_P0);
            end else begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                gnt0 = last_gnt;
                gnt1 = ~last_gnt;
`else
                gnt0 = 1'b1;
`endif
            end
        end
    end

    assign gnt_owner = gnt0 ? OWN_P0 : OWN_P1;

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        if (gnt0) begin
            mem_we   = we0;
            mem_addr = addr0;
            mem_data = wdata0;
        end else if (gnt1) begin
            mem_we   = we1;
            mem_addr = addr1;
            mem_data = wdata1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt   <= 1'b0;
            lock_owner <= OWN_NONE;
            lock_cnt   <= 4'd0;
            rd_pend    <= 1'b0;
            rd_port    <= 1'b0;
        end else begin
            if (gnt0 || gnt1)
                last_gnt <= gnt1;
            rd_pend <= (gnt0 && !we0) || (gnt1 && !we1);
            rd_port <= gnt1;
            // A fresh owner starts counting at one; an expired lock always clears.
            if (!expired && ((gnt0 && lock0) || (gnt1 && lock1))) begin
                lock_owner <= gnt_owner;
                lock_cnt   <= (lock_owner == gnt_owner) ? lock_cnt + 4'd1 : 4'd1;
            end else begin
                lock_owner <= OWN_NONE;
                lock_cnt   <= 4'd0;
            end
        end
    end

    assign rvalid0 = rd_pend && !rd_port;
    assign rvalid1 = rd_pend && rd_port;
    assign rdata0  = rvalid0 ? mem_in : '0;
    assign rdata1  = rvalid1 ? mem_in : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected grant/memory and read-return records, a monitor pops and compares.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 0, req1 = 0, lock0 = 0, lock1 = 0, we0 = 0, we1 = 0;
    logic [5:0]  addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [15:0] rdata0, rdata1, mem_data, mem_in;
    logic [5:0]  mem_addr;
    logic [15:0] mem [64];

    int checks = 0;
    int errors = 0;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  g;
        logic        we;
        logic [5:0]  a;
        logic [15:0] d;
    } gexp_t;
    typedef struct packed {
        logic        port;
        logic [15:0] d;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];

    mem_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .LOCK_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_in(mem_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_data;
        mem_in <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One arbitration cycle: drive both ports, record what the memory side and read path must show.
    task automatic cyc(input logic r0, input logic l0, input logic w0, input logic [5:0] a0,
                       input logic [15:0] d0, input logic r1, input logic l1, input logic w1,
                       input logic [5:0] a1, input logic [15:0] d1, input logic [1:0] eg,
                       input logic [15:0] erd, input bit push_rd);
        gexp_t e;
        rexp_t r;
        @(posedge clk);
        #1;
        req0 = r0; lock0 = l0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; lock1 = l1; we1 = w1; addr1 = a1; wdata1 = d1;
        e.g = eg; e.we = 1'b0; e.a = '0; e.d = '0;
        if (eg == 2'b01) begin e.we = w0; e.a = a0; e.d = d0; end
        if (eg == 2'b10) begin e.we = w1; e.a = a1; e.d = d1; end
        gq.push_back(e);
        if (eg != 2'b00 && !e.we && push_rd) begin
            r.port = eg[1];
            r.d    = erd;
            rq.push_back(r);
        end
    endtask

    task automatic idle();
        cyc(0, 0, 0, 6'd0, 16'h0, 0, 0, 0, 6'd0, 16'h0, 2'b00, 16'h0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (gq.size() > 0) begin
                gexp_t e;
                e = gq.pop_front();
                chk("gnt", 32'({gnt1, gnt0}), 32'(e.g));
                chk("mem_side", 32'({mem_we, mem_addr, mem_data}), 32'({e.we, e.a, e.d}));
            end
            if (rvalid0 || rvalid1) begin
                if (rq.size() == 0) begin
                    chk("spurious_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
                end else begin
                    rexp_t r;
                    logic [1:0] ev;
                    r  = rq.pop_front();
                    ev = r.port ? 2'b10 : 2'b01;
                    chk("rvalid", 32'({rvalid1, rvalid0}), 32'(ev));
                    chk("rdata", 32'({rdata1, rdata0}), r.port ? {r.d, 16'h0} : {16'h0, r.d});
                end
            end
        end
    end

    initial begin
        logic [1:0] eg;
        req0 = 1; we0 = 1; addr0 = 6'd5; wdata0 = 16'h7;
        #3;
        chk("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
        chk("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
        chk("rst_rdata", {rdata1, rdata0}, 32'd0);
        chk("rst_mem", 32'({mem_we, mem_addr, mem_data}), 32'd0);
        @(negedge clk);
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        chk("rel_mem_we", 32'(mem_we), 32'd0);
        chk("rel_mem_addr", 32'(mem_addr), 32'd0);

        // Port 1 write, then port 0 reads it back; then seed addr 20.
        cyc(0, 0, 0, 6'd0, 16'h0, 1, 0, 1, 6'd12, 16'hABCD, 2'b10, 16'h0, 1'b0);
        cyc(1, 0, 0, 6'd12, 16'h0, 0, 0, 0, 6'd0, 16'h0, 2'b01, 16'hABCD, 1'b1);
        cyc(1, 0, 1, 6'd20, 16'h1234, 0, 0, 0, 6'd0, 16'h0, 2'b01, 16'h0, 1'b0);
        // Back-to-back reads from alternating ports.
        cyc(0, 0, 0, 6'd0, 16'h0, 1, 0, 0, 6'd20, 16'h0, 2'b10, 16'h1234, 1'b1);
        cyc(1, 0, 0, 6'd12, 16'h0, 0, 0, 0, 6'd0, 16'h0, 2'b01, 16'hABCD, 1'b1);
        // Contention for four cycles.
        for (int i = 0; i < 4; i++) begin
            eg = (RR && (i % 2 == 0)) ? 2'b10 : 2'b01;
            cyc(1, 0, 0, 6'd12, 16'h0, 1, 0, 0, 6'd20, 16'h0, eg,
                (eg == 2'b10) ? 16'h1234 : 16'hABCD, 1'b1);
        end
        idle();

        // Locked sequence: port 0 holds for LOCK_MAX grants, then port 1 wins.
        cyc(1, 1, 1, 6'd40, 16'h0001, 0, 0, 0, 6'd41, 16'h0, 2'b01, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc(1, 1, 1, 6'd40, 16'(i + 2), 1, 0, 1, 6'd41, 16'h00F1, 2'b01, 16'h0, 1'b0);
        cyc(1, 1, 1, 6'd40, 16'h0005, 1, 0, 1, 6'd41, 16'h00F1, 2'b10, 16'h0, 1'b0);
        cyc(1, 1, 1, 6'd40, 16'h0006, 1, 0, 1, 6'd41, 16'h00F2, 2'b01, 16'h0, 1'b0);
        chk("lock_cnt_clr", 32'(dut.lock_cnt), 32'd0);
        cyc(1, 1, 1, 6'd40, 16'h0007, 1, 0, 1, 6'd41, 16'h00F2, 2'b01, 16'h0, 1'b0);
        // Lock owner drops req: port 1 granted in that same cycle.
        cyc(0, 1, 1, 6'd40, 16'h0008, 1, 0, 1, 6'd41, 16'h00F3, 2'b10, 16'h0, 1'b0);
        idle();

        // Granted read then a reset pulse before the next edge: read is dropped.
        cyc(1, 0, 0, 6'd12, 16'h0, 0, 0, 0, 6'd0, 16'h0, 2'b01, 16'h0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        req0 = 1'b0;
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_drop_rvalid0", 32'(rvalid0), 32'd0);
        chk("rst_drop_rdata0", 32'(rdata0), 32'd0);
        idle();
        idle();
        @(negedge clk);
        #1;
        chk("queues_drained", 32'(gq.size() + rq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
